macro_expander: RTL and testbench
=================================

Name: macro_expander

Overview:
- Parametrised successor to the single-opcode instruction decoder.
- Latches one IN_W-bit macro-instruction and looks its opcode up in a fixed expansion table.
- Emits 1..MAX_UOPS OUT_W-bit micro-ops, one per valid/ack handshake with the instruction memory writer. Each micro-op carries an auto-incrementing write address.
- Unknown opcodes are flagged with an error pulse instead of being silently dropped.

Parameters:
- BYTE, 8, opcode/operand field width.
- IN_W, 16, macro-instruction width: opcode is [IN_W-1:IN_W-BYTE], operand is [BYTE-1:0].
- OUT_W, 32, micro-op width.
- ADDR_W, 16, memory address width.
- MAX_UOPS, 4, maximum micro-ops per opcode; sizes the index counter.
- BASE_ADDR, 0, address loaded at reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  accept instruction_in; honoured only while ready=1
- instruction_in  in  IN_W  macro-instruction, sampled on the start cycle only
- ready  out  1  idle, can accept start
- uop_out  out  OUT_W  current micro-op
- uop_valid  out  1  uop_out/addr_out valid; held until uop_ack
- uop_ack  in  1  consumer accepts the current micro-op this cycle
- addr_out  out  ADDR_W  write address for uop_out
- done  out  1  one-cycle pulse after the last micro-op is accepted
- error  out  1  one-cycle pulse for an unknown opcode

Behaviour:
- All outputs are registered.
- Reset (reset=0 at posedge): state=IDLE, ready=1, uop_valid=0, uop_out=0, done=0, error=0, addr register=BASE_ADDR, index=0. Reset overrides everything, including mid-expansion; a pending micro-op is dropped.
- States: IDLE, ISSUE, FIN, ERR.
- IDLE:
  - ready=1.
  - On start=1: latch the opcode/operand, look up count and templates, set ready=0.
  - If count==0, go to ERR.
  - Otherwise go to ISSUE with index=0, uop_valid=1, uop_out=word0.
  - First uop_valid appears 1 cycle after the start edge.
- Micro-op formation: uop_out = {template[OUT_W-1:BYTE], operand}, i.e. the template low byte is replaced by the latched operand.
- addr_out is the current address register.
- ISSUE:
  - uop_valid, uop_out and addr_out stay stable while uop_ack=0.
  - On uop_ack=1: address += 1, wrapping modulo 2^ADDR_W (FFFF->0000).
  - If index < count-1: index += 1 and the next word is presented in the following cycle. Valid stays high, so back-to-back accept is one micro-op per cycle.
  - Else: uop_valid=0 and go to FIN.
- FIN: done=1 for one cycle, then IDLE with ready=1. done and ready are never high together.
- ERR: error=1 for one cycle, address unchanged, then IDLE.
- start while ready=0 is ignored. instruction_in changes after the start cycle have no effect.
- The address register persists across instructions and is cleared only by reset.
- uop_ack while uop_valid=0 is ignored.

Decomposition:
- Package macro_pkg holds:
  - state encoding localparams;
  - opcode constants: OP_I2B=8'h91, OP_I2H=8'h92, OP_I2W=8'h93;
  - per-opcode count and template words:
    - 91: count 1 — 920104xx
    - 92: count 2 — 930104xx, 940204xx
    - 93: count 4 — 950104xx, 960204xx, 970304xx, 980404xx
  - All other opcodes have count 0.
- Sub-module macro_rom: combinational opcode+index -> {count, template}. The top level holds the FSM, index counter, address counter and output registers.

Test Plan:
- Reset then start with 16'h91E0, uop_ack tied 1 -> one cycle later uop_out=32'h920104E0, addr_out=0000, uop_valid=1; next cycle done=1; addr register=0001; ready returns to 1 the following cycle.
- Start 16'h9205 with uop_ack held 0 for 3 cycles, then 1 -> 930104 05 held stable at addr 0000 for 4 cycles; then 94020405 at 0001; done pulse after its ack.
- Start 16'h9300 with uop_ack=1 continuously -> four consecutive valid cycles at addresses 0000..0003; done on the 5th cycle; start asserted during expansion is ignored.
- Start 16'h1234 -> error=1 one cycle after start, no uop_valid, address unchanged, ready=1 the cycle after.
- Force the address to FFFF via 65535 accepted i2b micro-ops (or BASE_ADDR=16'hFFFF), then start 16'h9211 -> addresses FFFF then 0000.
- Assert reset=0 during the second micro-op of 16'h9300 -> next cycle uop_valid=0, ready=1, addr=BASE_ADDR, done=0.

Source files
------------

// File: rtl/macro_expander_pkg.sv
// Shared definitions for the macro-instruction expander: FSM states,
// opcode constants and the fixed expansion table.
package macro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FIN,
    ERR
  } state_t;

  localparam logic [7:0] OP_I2B = 8'h91;
  localparam logic [7:0] OP_I2H = 8'h92;
  localparam logic [7:0] OP_I2W = 8'h93;

  function automatic int unsigned uop_count(input logic [7:0] op);
    case (op)
      OP_I2B:  return 1;
      OP_I2H:  return 2;
      OP_I2W:  return 4;
      default: return 0;
    endcase
  endfunction

  // Template words minus their low byte, which is always the operand.
  function automatic logic [23:0] uop_template_hi(input logic [7:0] op,
                                                  input logic [1:0] idx);
    case ({op, idx})
      {OP_I2B, 2'd0}: return 24'h920104;
      {OP_I2H, 2'd0}: return 24'h930104;
      {OP_I2H, 2'd1}: return 24'h940204;
      {OP_I2W, 2'd0}: return 24'h950104;
      {OP_I2W, 2'd1}: return 24'h960204;
      {OP_I2W, 2'd2}: return 24'h970304;
      {OP_I2W, 2'd3}: return 24'h980404;
      default:        return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/macro_expander_rom.sv
// Combinational expansion table: opcode and micro-op index to
// micro-op count and template upper bits.
module macro_rom #(
  parameter int unsigned BYTE  = 8,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic [BYTE-1:0]       opcode,
  input  logic [IDX_W-1:0]      index,
  output logic [CNT_W-1:0]      count,
  output logic [OUT_W-BYTE-1:0] tmpl_hi
);
  import macro_pkg::*;

  always_comb begin
    count   = CNT_W'(uop_count(8'(opcode)));
    tmpl_hi = (OUT_W-BYTE)'(uop_template_hi(8'(opcode), 2'(index)));
  end

endmodule

// File: rtl/macro_expander.sv
// Expands one latched macro-instruction into a sequence of micro-ops,
// each handed to the instruction-memory writer with a valid/ack handshake.
module macro_expander #(
  parameter int unsigned BYTE      = 8,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_UOPS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IN_W-1:0]   instruction_in,
  output logic              ready,
  output logic [OUT_W-1:0]  uop_out,
  output logic              uop_valid,
  input  logic              uop_ack,
  output logic [ADDR_W-1:0] addr_out,
  output logic              done,
  output logic              error
);
  import macro_pkg::*;

  localparam int unsigned IDX_W = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_UOPS + 1);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [OUT_W-1:0]    uop_q, uop_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BYTE-1:0]     opcode_q, opcode_d;
  logic [BYTE-1:0]     operand_q, operand_d;

  logic [BYTE-1:0]       rom_opcode;
  logic [IDX_W-1:0]      rom_index;
  logic [CNT_W-1:0]      rom_count;
  logic [OUT_W-BYTE-1:0] rom_tmpl_hi;

  // A single table port: in IDLE it decodes the incoming instruction,
  // otherwise it looks ahead to the word after the one being presented.
  always_comb begin
    if (state_q == IDLE) begin
      rom_opcode = instruction_in[IN_W-1 -: BYTE];
      rom_index  = '0;
    end else begin
      rom_opcode = opcode_q;
      rom_index  = index_q + IDX_W'(1);
    end
  end

  macro_rom #(
    .BYTE  (BYTE),
    .OUT_W (OUT_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_rom (
    .opcode  (rom_opcode),
    .index   (rom_index),
    .count   (rom_count),
    .tmpl_hi (rom_tmpl_hi)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      uop_q     <= '0;
      addr_q    <= BASE_ADDR;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      index_q   <= '0;
      count_q   <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      uop_q     <= uop_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      index_q   <= index_d;
      count_q   <= count_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    uop_d     = uop_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    index_d   = index_q;
    count_d   = count_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          opcode_d  = instruction_in[IN_W-1 -: BYTE];
          operand_d = instruction_in[BYTE-1:0];
          count_d   = rom_count;
          index_d   = '0;
          ready_d   = 1'b0;
          if (rom_count == '0) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
            uop_d   = {rom_tmpl_hi, instruction_in[BYTE-1:0]};
          end
        end
      end
      ISSUE: begin
        if (uop_ack) begin
          addr_d = addr_q + ADDR_W'(1);
          if (CNT_W'(index_q) < count_q - CNT_W'(1)) begin
            index_d = index_q + IDX_W'(1);
            uop_d   = {rom_tmpl_hi, operand_q};
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN, ERR: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = ready_q;
  assign uop_out   = uop_q;
  assign uop_valid = valid_q;
  assign addr_out  = addr_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_macro_expander.sv
// Self-checking bench for macro_expander: directed scenarios plus randomized
// instructions and ack stalls against a table-driven reference model.
module tb_macro_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, uop_ack;
  logic [15:0] instruction_in;
  logic        ready, uop_valid, done, error;
  logic [31:0] uop_out;
  logic [15:0] addr_out;

  logic        start2, uop_ack2;
  logic [15:0] instruction_in2;
  logic        ready2, uop_valid2, done2, error2;
  logic [31:0] uop_out2;
  logic [15:0] addr_out2;

  int checks   = 0;
  int failures = 0;
  int unsigned ref_addr = 0;

  macro_expander dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .instruction_in (instruction_in),
    .ready          (ready),
    .uop_out        (uop_out),
    .uop_valid      (uop_valid),
    .uop_ack        (uop_ack),
    .addr_out       (addr_out),
    .done           (done),
    .error          (error)
  );

  macro_expander #(.BASE_ADDR(16'hFFFF)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .start          (start2),
    .instruction_in (instruction_in2),
    .ready          (ready2),
    .uop_out        (uop_out2),
    .uop_valid      (uop_valid2),
    .uop_ack        (uop_ack2),
    .addr_out       (addr_out2),
    .done           (done2),
    .error          (error2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_count(input logic [7:0] op);
    if (op == 8'h91) return 1;
    if (op == 8'h92) return 2;
    if (op == 8'h93) return 4;
    return 0;
  endfunction

  // Word k of an expansion: top byte counts up from a per-opcode base,
  // next byte is k+1, then 04, then the operand.
  function automatic logic [31:0] ref_uop(input logic [15:0] instr, input int unsigned k);
    logic [7:0] base;
    base = (instr[15:8] == 8'h91) ? 8'h92 : (instr[15:8] == 8'h92) ? 8'h93 : 8'h95;
    return {base + 8'(k), 8'(k + 1), 8'h04, instr[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] instr, input int unsigned stall_lo,
                           input int unsigned stall_hi);
    int unsigned n, stall, waited;
    waited = 0;
    while (ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check_eq("ready_before_start", 64'(ready), 64'd1);
    n = ref_count(instr[15:8]);
    start = 1'b1;
    instruction_in = instr;
    tick();
    start = 1'b0;
    instruction_in = 16'($urandom);
    if (n == 0) begin
      check_eq("err_pulse", 64'(error), 64'd1);
      check_eq("err_no_valid", 64'(uop_valid), 64'd0);
      check_eq("err_ready_low", 64'(ready), 64'd0);
      start = 1'($urandom);
      tick();
      start = 1'b0;
      check_eq("err_pulse_end", 64'(error), 64'd0);
      check_eq("err_ready_back", 64'(ready), 64'd1);
      check_eq("err_addr_kept", 64'(addr_out), 64'(ref_addr));
      check_eq("err_valid_low", 64'(uop_valid), 64'd0);
    end else begin
      for (int unsigned k = 0; k < n; k++) begin
        stall = $urandom_range(stall_hi, stall_lo);
        for (int unsigned s = 0; s <= stall; s++) begin
          check_eq("uop_valid", 64'(uop_valid), 64'd1);
          check_eq("uop_out", 64'(uop_out), 64'(ref_uop(instr, k)));
          check_eq("addr_out", 64'(addr_out), 64'(ref_addr));
          check_eq("busy_not_ready", 64'(ready), 64'd0);
          check_eq("no_done_yet", 64'(done), 64'd0);
          uop_ack = (s == stall);
          start = 1'($urandom);
          instruction_in = 16'($urandom);
          tick();
        end
        ref_addr = (ref_addr + 1) & 32'hFFFF;
      end
      uop_ack = 1'b0;
      start = 1'b0;
      check_eq("fin_valid_low", 64'(uop_valid), 64'd0);
      check_eq("fin_done", 64'(done), 64'd1);
      check_eq("fin_not_ready", 64'(ready), 64'd0);
      check_eq("fin_addr", 64'(addr_out), 64'(ref_addr));
      uop_ack = 1'($urandom);
      start = 1'($urandom);
      tick();
      start = 1'b0;
      uop_ack = 1'b0;
      check_eq("done_pulse_end", 64'(done), 64'd0);
      check_eq("ready_after_fin", 64'(ready), 64'd1);
      check_eq("idle_valid_low", 64'(uop_valid), 64'd0);
      check_eq("idle_addr", 64'(addr_out), 64'(ref_addr));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    int unsigned sel;
    reset = 1'b0;
    start = 1'b0;
    uop_ack = 1'b0;
    instruction_in = '0;
    start2 = 1'b0;
    uop_ack2 = 1'b0;
    instruction_in2 = '0;
    tick();
    tick();
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_valid", 64'(uop_valid), 64'd0);
    check_eq("rst_uop", 64'(uop_out), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_addr", 64'(addr_out), 64'd0);
    check_eq("rst_addr_wrap_dut", 64'(addr_out2), 64'hFFFF);
    reset = 1'b1;
    tick();

    run_instr(16'h91E0, 0, 0);
    run_instr(16'h9205, 3, 3);
    run_instr(16'h9300, 0, 0);
    run_instr(16'h1234, 0, 0);

    // Reset during the second micro-op of an i2w expansion.
    start = 1'b1;
    instruction_in = 16'h9300;
    tick();
    start = 1'b0;
    uop_ack = 1'b1;
    tick();
    check_eq("mid_second_uop", 64'(uop_out), 64'(ref_uop(16'h9300, 1)));
    check_eq("mid_second_addr", 64'(addr_out), 64'((ref_addr + 1) & 32'hFFFF));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    uop_ack = 1'b0;
    ref_addr = 0;
    check_eq("mid_rst_valid", 64'(uop_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(ready), 64'd1);
    check_eq("mid_rst_addr", 64'(addr_out), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    tick();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(3, 0);
      op = (sel == 0) ? 8'h91 : (sel == 1) ? 8'h92 : (sel == 2) ? 8'h93 : 8'($urandom);
      run_instr({op, 8'($urandom)}, 0, 3);
    end

    // Address wrap on the instance whose base address is FFFF.
    start2 = 1'b1;
    instruction_in2 = 16'h9211;
    tick();
    start2 = 1'b0;
    instruction_in2 = 16'h0000;
    check_eq("wrap_valid0", 64'(uop_valid2), 64'd1);
    check_eq("wrap_uop0", 64'(uop_out2), 64'h93010411);
    check_eq("wrap_addr0", 64'(addr_out2), 64'hFFFF);
    uop_ack2 = 1'b1;
    tick();
    check_eq("wrap_valid1", 64'(uop_valid2), 64'd1);
    check_eq("wrap_uop1", 64'(uop_out2), 64'h94020411);
    check_eq("wrap_addr1", 64'(addr_out2), 64'h0000);
    tick();
    uop_ack2 = 1'b0;
    check_eq("wrap_done", 64'(done2), 64'd1);
    check_eq("wrap_error", 64'(error2), 64'd0);
    tick();
    check_eq("wrap_ready", 64'(ready2), 64'd1);
    check_eq("wrap_addr_end", 64'(addr_out2), 64'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
